qpsk_symbol_scheduler: RTL and testbench

Sequences the 3-bit LFSR pseudo-random bit source that feeds the QPSK modulator. It reseeds the source at the start of each burst and gates the source advance. It pairs consecutive source bits into I/Q dibits and hands each dibit downstream over a valid/ready handshake, for a programmed number of symbols or continuously. It sits between the bit source and the QPSK mapper in the modulator top level.

---
 rtl/qpsk_pkg.sv | 19 +
 rtl/qpsk_symbol_scheduler.sv | 95 +++++++++
 tb/tb_qpsk_symbol_scheduler.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/qpsk_pkg.sv
// Shared types and constants for the QPSK bit-source scheduler and its
// neighbours in the modulator top level.
package qpsk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESEED = 3'd1,
    ST_GET_I  = 3'd2,
    ST_GET_Q  = 3'd3,
    ST_SEND   = 3'd4,
    ST_DONE   = 3'd5
  } sched_state_t;

  // Value the bit source loads while src_reseed is high.
  localparam logic [2:0] SRC_SEED = 3'b001;

  typedef logic [1:0] dibit_t;

endpackage

// File: rtl/qpsk_symbol_scheduler.sv
// Reseeds and gates the LFSR bit source, pairs bits into {I,Q} dibits and
// hands them downstream over valid/ready, for a fixed length or continuously.
module qpsk_symbol_scheduler
  import qpsk_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             src_bit,
  output logic             src_en,
  output logic             src_reseed,
  output logic [1:0]       sym_data,
  output logic             sym_valid,
  input  logic             sym_ready,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] sym_count
);

  sched_state_t     state_q, state_d;
  logic             i_q, i_d;
  logic             q_q, q_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] count_inc;
  dibit_t           dibit;

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    q_d       = q_q;
    count_d   = count_q;
    len_d     = len_q;
    count_inc = count_q + LEN_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_RESEED;
          len_d   = burst_len;
          count_d = '0;
        end
      end
      ST_RESEED: state_d = ST_GET_I;
      ST_GET_I: begin
        i_d     = src_bit;
        state_d = ST_GET_Q;
      end
      ST_GET_Q: begin
        q_d     = src_bit;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        // A handshake coinciding with abort still counts: the transfer happened.
        if (sym_ready) begin
          count_d = count_inc;
          state_d = ((len_q != '0) && (count_inc == len_q)) ? ST_DONE : ST_GET_I;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= 1'b0;
      q_q     <= 1'b0;
      count_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      q_q     <= q_d;
      count_q <= count_d;
      len_q   <= len_d;
    end
  end

  // Every output is a decode of registered state, so none depends on inputs.
  assign dibit      = (state_q == ST_SEND) ? {i_q, q_q} : 2'b00;
  assign sym_data   = dibit;
  assign sym_valid  = (state_q == ST_SEND);
  assign src_en     = (state_q == ST_GET_I) || (state_q == ST_GET_Q);
  assign src_reseed = (state_q == ST_RESEED);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign sym_count  = count_q;

endmodule

// File: tb/tb_qpsk_symbol_scheduler.sv
// Directed bench for qpsk_symbol_scheduler with a 3-bit LFSR bit source model.
module tb_qpsk_symbol_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] burst_len = 8'd0;
  logic       src_bit;
  logic       src_en;
  logic       src_reseed;
  logic [1:0] sym_data;
  logic       sym_valid;
  logic       sym_ready = 1'b1;
  logic       busy;
  logic       done;
  logic [7:0] sym_count;

  logic [2:0] lfsr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] got [$];
  logic [1:0] gold [7] = '{2'd2, 2'd1, 2'd1, 2'd3, 2'd0, 2'd2, 2'd3};

  typedef struct {
    logic       start;
    logic [7:0] len;
    logic [6:0] exp;
  } vec_t;
  vec_t tv [$];

  always #5 clk = ~clk;

  // Bit source: shift right, feedback s0^s1; from 001 its lsb runs 1,0,0,1,0,1,1.
  always_ff @(posedge clk) begin
    if (rst || src_reseed) lfsr <= 3'b001;
    else if (src_en)       lfsr <= {lfsr[0] ^ lfsr[1], lfsr[2:1]};
  end
  assign src_bit = lfsr[0];

  qpsk_symbol_scheduler #(.LEN_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .burst_len  (burst_len),
    .src_bit    (src_bit),
    .src_en     (src_en),
    .src_reseed (src_reseed),
    .sym_data   (sym_data),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .busy       (busy),
    .done       (done),
    .sym_count  (sym_count)
  );

  function automatic logic [6:0] outs();
    return {busy, sym_valid, done, src_en, src_reseed, sym_data};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_seq(input string nm, input int n);
    chk({nm, "_len"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++)
      chk($sformatf("%s_sym%0d", nm, i), got[i], gold[i % 7]);
  endtask

  // Runs one burst from IDLE; cycle k counts from the edge accepting start.
  task automatic run_burst(input logic [7:0] len, input int stall_sym, input int stall_n,
                           input int abort_sym, input bit abort_on_hs, input int start_cyc,
                           output int done_cyc, output int ndone, output int abort_cyc,
                           output int idle_cyc);
    int k, stalls, nhs;
    bit fin, aborted, prev_en;
    logic [1:0] held;
    got.delete();
    stalls = 0; nhs = 0; ndone = 0; done_cyc = -1; abort_cyc = -1; idle_cyc = -1;
    fin = 0; aborted = 0; prev_en = 0; held = 2'b00;
    burst_len = len; start = 1'b1; abort = 1'b0; sym_ready = 1'b1;
    step();
    k = 1;
    while (!fin && k < 2000) begin
      start = (k == start_cyc);
      abort = 1'b0;
      sym_ready = 1'b1;
      if (done) begin ndone++; done_cyc = k; end
      if (!busy) begin
        fin = 1;
        idle_cyc = k;
      end else begin
        if (abort_sym > 0 && !aborted && nhs == abort_sym - 1) begin
          if ((abort_on_hs && sym_valid) || (!abort_on_hs && src_en && prev_en)) begin
            abort = 1'b1; aborted = 1; abort_cyc = k;
          end
        end
        if (sym_valid) begin
          if (nhs == stall_sym && stalls < stall_n) begin
            sym_ready = 1'b0;
            if (stalls == 0) held = sym_data;
            else chk($sformatf("stall_hold%0d", stalls), sym_data, held);
            stalls++;
          end else begin
            if (stalls > 0 && nhs == stall_sym) chk("stall_release", sym_data, held);
            got.push_back(sym_data);
            nhs++;
          end
        end
      end
      prev_en = src_en;
      if (!fin) begin
        step();
        k++;
      end
    end
    start = 1'b0; abort = 1'b0; sym_ready = 1'b1;
    if (!fin) begin
      n_tests++; n_fail++;
      $display("FAIL burst_timeout: busy still %0b after %0d cycles", busy, k);
    end
  endtask

  initial begin
    int dc, nd, ac, ic, dc_base;

    // Reset held from time 0
    #1;
    chk("reset_outs", outs(), 7'd0);
    chk("reset_count", sym_count, 8'd0);
    step(); step();
    rst = 1'b0;
    step();
    chk("idle_after_reset", outs(), 7'd0);

    // Golden burst of 7 as a cycle table
    tv.push_back('{1'b1, 8'd7, 7'b0000000});
    tv.push_back('{1'b0, 8'd7, 7'b1000100});
    for (int n = 0; n < 7; n++) begin
      tv.push_back('{1'b0, 8'd7, 7'b1001000});
      tv.push_back('{1'b0, 8'd7, 7'b1001000});
      tv.push_back('{1'b0, 8'd7, {5'b11000, gold[n]}});
    end
    tv.push_back('{1'b0, 8'd7, 7'b1010000});
    tv.push_back('{1'b0, 8'd7, 7'b0000000});
    for (int k = 0; k < tv.size(); k++) begin
      start = tv[k].start;
      burst_len = tv[k].len;
      abort = 1'b0;
      sym_ready = 1'b1;
      chk($sformatf("gold_cyc%0d", k), outs(), tv[k].exp);
      step();
    end
    start = 1'b0;
    chk("gold_count", sym_count, 8'd7);

    // Baseline and backpressured bursts of 3
    run_burst(8'd3, -1, 0, 0, 0, -1, dc, nd, ac, ic);
    dc_base = dc;
    chk_seq("base3", 3);
    chk("base3_done_cyc", dc, 11);
    chk("base3_ndone", nd, 1);
    chk("base3_count", sym_count, 8'd3);
    chk("base3_busy_fall", ic, dc + 1);

    run_burst(8'd3, 1, 5, 0, 0, -1, dc, nd, ac, ic);
    chk_seq("stall3", 3);
    chk("stall3_extra", dc - dc_base, 5);
    chk("stall3_ndone", nd, 1);
    chk("stall3_count", sym_count, 8'd3);

    // Continuous, abort in GET_Q of symbol 4
    run_burst(8'd0, -1, 0, 4, 0, -1, dc, nd, ac, ic);
    chk("abortq_cyc", ac, 12);
    chk("abortq_idle_next", ic, ac + 1);
    chk("abortq_ndone", nd, 0);
    chk("abortq_count", sym_count, 8'd3);
    run_burst(8'd1, -1, 0, 0, 0, -1, dc, nd, ac, ic);
    chk_seq("restart", 1);
    chk("restart_ndone", nd, 1);

    // Abort together with the handshake of symbol 2
    run_burst(8'd5, -1, 0, 2, 1, -1, dc, nd, ac, ic);
    chk("aborths_count", sym_count, 8'd2);
    chk("aborths_ndone", nd, 0);
    chk_seq("aborths", 2);

    // Start pulsed mid-burst is ignored
    run_burst(8'd2, -1, 0, 0, 0, 5, dc, nd, ac, ic);
    chk_seq("midstart", 2);
    chk("midstart_done_cyc", dc, 8);
    chk("midstart_count", sym_count, 8'd2);

    // start with abort in IDLE: abort wins, count untouched
    burst_len = 8'd9; start = 1'b1; abort = 1'b1;
    step();
    chk("startabort_busy", busy, 1'b0);
    start = 1'b0; abort = 1'b0;
    step();
    chk("startabort_still_idle", outs(), 7'd0);
    chk("startabort_count", sym_count, 8'd2);

    // Maximum finite burst
    run_burst(8'd255, -1, 0, 0, 0, -1, dc, nd, ac, ic);
    chk("max_count", sym_count, 8'd255);
    chk("max_ndone", nd, 1);
    chk("max_done_cyc", dc, 767);

    // Continuous run of 260 symbols wraps the counter
    run_burst(8'd0, -1, 0, 261, 0, -1, dc, nd, ac, ic);
    chk("wrap_count", sym_count, 8'd4);
    chk("wrap_ndone", nd, 0);

    // Asynchronous reset mid-burst, then a fresh burst starts from dibit 2
    burst_len = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("pre_reset_busy", busy, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk("midreset_outs", outs(), 7'd0);
    chk("midreset_count", sym_count, 8'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_reset_idle", outs(), 7'd0);
    run_burst(8'd2, -1, 0, 0, 0, -1, dc, nd, ac, ic);
    chk_seq("post_reset", 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
